// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the instruction/data memory port arbiter.
//   owner_e     : identifies which unit issued a memory transaction
//   other_owner : returns the opposite owner (round-robin helper)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// ---------------------------------------------------------------------------
// owner_fifo
// Small FIFO recording the owner of every granted memory transaction so
// that responses can be routed back in issue order.
//   clk_i, rst_i : clock, synchronous active-high reset (discards entries)
//   push_i/data_i: enqueue an owner
//   pop_i        : dequeue the head (ignored while empty)
//   full_o/empty_o, head_o : status and oldest owner
// A push while full is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  owner_e data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output owner_e head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    owner_e           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // Freeing the head slot this cycle makes room for the incoming entry.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one req/gnt/rvalid memory port between instruction fetch and
// load/store. Round-robin selection with a lock that holds a stalled
// request until granted; zero-latency request path; responses routed by
// an owner FIFO recording every granted transaction.
//   instr_*  : fetch port (read-only)
//   data_*   : load/store port
//   mem_*    : shared memory port
//   err_o    : sticky, set by an rvalid with nothing outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_adr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    input  logic              data_req_i,
    input  logic [ADDR_W-1:0] data_adr_i,
    input  logic              data_we_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    owner_e sel;
    owner_e last_grant_q, last_grant_d;
    owner_e lock_owner_q, lock_owner_d;
    owner_e head;
    logic   lock_q, lock_d;
    logic   err_q, err_d;
    logic   fifo_full, fifo_empty;
    logic   pop, block, granted, resp_ok;

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (granted),
        .data_i  (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // A stalled request keeps its selection; otherwise round-robin.
    always_comb begin
        sel = OWNER_INSTR;
        if (lock_q)                        sel = lock_owner_q;
        else if (instr_req_i && data_req_i) sel = other_owner(last_grant_q);
        else if (data_req_i)                sel = OWNER_DATA;
    end

    assign resp_ok = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign pop     = resp_ok;
    assign block   = fifo_full & ~pop;
    assign mem_req_o = (instr_req_i | data_req_i) & ~block & ~rst_i;
    assign granted   = mem_req_o & mem_gnt_i;

    assign mem_adr_o   = (sel == OWNER_DATA) ? data_adr_i   : instr_adr_i;
    assign mem_we_o    = (sel == OWNER_DATA) & data_we_i;
    assign mem_wdata_o = (sel == OWNER_DATA) ? data_wdata_i : '0;

    assign instr_gnt_o = granted & (sel == OWNER_INSTR);
    assign data_gnt_o  = granted & (sel == OWNER_DATA);

    assign instr_rvalid_o = resp_ok & (head == OWNER_INSTR);
    assign data_rvalid_o  = resp_ok & (head == OWNER_DATA);
    assign instr_rdata_o  = rst_i ? '0 : mem_rdata_i;
    assign data_rdata_o   = rst_i ? '0 : mem_rdata_i;

    assign err_o = err_q;

    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | (mem_rvalid_i & fifo_empty);
        if (granted) begin
            lock_d       = 1'b0;
            last_grant_d = sel;
        end else if (mem_req_o) begin
            lock_d       = 1'b1;
            lock_owner_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INSTR;
            last_grant_q <= OWNER_INSTR;
            err_q        <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Bench for mem_port_arbiter: acts as a 1-cycle-latency memory, keeps a
// queue of expected grants and a queue of expected responses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_adr_i;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_adr_i;
    logic        data_we_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_adr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_OUTSTANDING (2),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_adr_i    (instr_adr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_adr_i     (data_adr_i),
        .data_we_i      (data_we_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_adr_o      (mem_adr_o),
        .mem_we_o       (mem_we_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    typedef struct {
        owner_e      owner;
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        owner_e      owner;
        logic [31:0] rdata;
    } rsp_t;

    gnt_t        gnt_exp_q[$];
    rsp_t        rsp_exp_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    bit          rsp_hold = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_gnt(input owner_e o, input logic [31:0] adr,
                            input logic we, input logic [31:0] wdata);
        gnt_t g;
        g.owner = o; g.adr = adr; g.we = we; g.wdata = wdata;
        gnt_exp_q.push_back(g);
    endtask

    // Memory side: present the oldest pending response unless withheld.
    task automatic mem_drive();
        if (!rsp_hold && rsp_q.size() > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rsp_q.pop_front();
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
    endtask

    task automatic observe();
        gnt_t        g;
        rsp_t        r;
        logic [31:0] rd;
        if (mem_rvalid_i) begin
            if (rsp_exp_q.size() > 0) begin
                r = rsp_exp_q.pop_front();
                check("rvalid_instr", instr_rvalid_o, r.owner == OWNER_INSTR);
                check("rvalid_data",  data_rvalid_o,  r.owner == OWNER_DATA);
                check("rdata", (r.owner == OWNER_INSTR) ? instr_rdata_o : data_rdata_o, r.rdata);
            end else begin
                check("stray_routed", {instr_rvalid_o, data_rvalid_o}, 2'b00);
            end
        end else begin
            check("rvalid_idle", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        end
        if (mem_req_o && mem_gnt_i) begin
            if (gnt_exp_q.size() == 0) begin
                check("unexpected_gnt", {mem_req_o, mem_gnt_i}, 2'b00);
            end else begin
                g = gnt_exp_q.pop_front();
                check("gnt_instr", instr_gnt_o, g.owner == OWNER_INSTR);
                check("gnt_data",  data_gnt_o,  g.owner == OWNER_DATA);
                check("gnt_adr",   mem_adr_o,   g.adr);
                check("gnt_we",    mem_we_o,    g.we);
                if (g.we) begin
                    check("gnt_wdata", mem_wdata_o, g.wdata);
                    mem_model[g.adr] = g.wdata;
                    rd = '0;
                end else begin
                    rd = mem_model.exists(g.adr) ? mem_model[g.adr] : (g.adr ^ 32'h5A5A_5A5A);
                end
                rsp_q.push_back(rd);
                r.owner = g.owner;
                r.rdata = rd;
                rsp_exp_q.push_back(r);
            end
        end else begin
            check("gnt_idle", {instr_gnt_o, data_gnt_o}, 2'b00);
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic drain(input int unsigned n);
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_i = 1'b1; instr_req_i = 1'b0; instr_adr_i = '0;
        data_req_i = 1'b0; data_adr_i = '0; data_we_i = 1'b0; data_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        @(posedge clk); #1;

        // Reset: requests and grants present but suppressed
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_gnts", {instr_gnt_o, data_gnt_o}, 2'b00);
        check("rst_err", err_o, 1'b0);
        step(); step();
        rst_i = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0;
        #1;
        check("idle_mem_req", mem_req_o, 1'b0);
        step();

        // Instr-only stream
        for (int i = 0; i < 3; i++) begin
            instr_req_i = 1'b1;
            instr_adr_i = 32'h1A00_0000 + 32'(i * 4);
            push_gnt(OWNER_INSTR, instr_adr_i, 1'b0, '0);
            #1;
            check("instr_same_cycle_gnt", instr_gnt_o, 1'b1);
            step();
        end
        drain(2);

        // Contention after reset: DATA first, then alternate
        rst_i = 1'b1; step(); rst_i = 1'b0;
        instr_req_i = 1'b1; instr_adr_i = 32'h1A00_0100;
        data_req_i  = 1'b1; data_adr_i  = 32'h1A00_0200;
        push_gnt(OWNER_DATA,  32'h1A00_0200, 1'b0, '0);
        push_gnt(OWNER_INSTR, 32'h1A00_0100, 1'b0, '0);
        push_gnt(OWNER_DATA,  32'h1A00_0200, 1'b0, '0);
        push_gnt(OWNER_INSTR, 32'h1A00_0100, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();
        drain(2);

        // Stall lock: INSTR held despite DATA having priority
        mem_gnt_i = 1'b0;
        instr_req_i = 1'b1; instr_adr_i = 32'h1A00_0300;
        #1;
        check("lock_first_adr", mem_adr_o, 32'h1A00_0300);
        step();
        data_req_i = 1'b1; data_adr_i = 32'h1A00_0400;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_adr_held", mem_adr_o, 32'h1A00_0300);
            check("lock_req_held", mem_req_o, 1'b1);
            step();
        end
        mem_gnt_i = 1'b1;
        push_gnt(OWNER_INSTR, 32'h1A00_0300, 1'b0, '0);
        step();
        instr_req_i = 1'b0;
        push_gnt(OWNER_DATA, 32'h1A00_0400, 1'b0, '0);
        step();
        drain(2);

        // Full FIFO: two outstanding, third request blocked until a response
        rsp_hold = 1'b1;
        instr_req_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr_adr_i = 32'h1A00_0500 + 32'(i * 4);
            push_gnt(OWNER_INSTR, instr_adr_i, 1'b0, '0);
            step();
        end
        instr_adr_i = 32'h1A00_0508;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("full_blocked", mem_req_o, 1'b0);
            step();
        end
        rsp_hold = 1'b0;
        mem_drive();
        push_gnt(OWNER_INSTR, 32'h1A00_0508, 1'b0, '0);
        #1;
        check("full_pushpop_req", mem_req_o, 1'b1);
        check("full_pushpop_gnt", instr_gnt_o, 1'b1);
        step();
        drain(3);

        // Store then load of the same word
        data_req_i = 1'b1; data_adr_i = 32'h1A00_0010;
        data_we_i = 1'b1; data_wdata_i = 32'hDEAD_BEEF;
        push_gnt(OWNER_DATA, 32'h1A00_0010, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("store_we", mem_we_o, 1'b1);
        step();
        data_we_i = 1'b0;
        push_gnt(OWNER_DATA, 32'h1A00_0010, 1'b0, '0);
        #1;
        check("load_we", mem_we_o, 1'b0);
        step();
        data_req_i = 1'b0;
        #1;
        check("load_rvalid", data_rvalid_o, 1'b1);
        check("load_rdata", data_rdata_o, 32'hDEAD_BEEF);
        step();
        drain(2);

        // Reset with one transaction in flight, then its late response
        rsp_hold = 1'b1;
        instr_req_i = 1'b1; instr_adr_i = 32'h1A00_0600;
        push_gnt(OWNER_INSTR, 32'h1A00_0600, 1'b0, '0);
        step();
        instr_req_i = 1'b0;
        rst_i = 1'b1;
        rsp_exp_q.delete();
        step();
        check("midrst_err_clear", err_o, 1'b0);
        rst_i = 1'b0;
        rsp_hold = 1'b0;
        mem_drive();
        #1;
        check("stray_no_instr_rvalid", instr_rvalid_o, 1'b0);
        check("stray_no_data_rvalid", data_rvalid_o, 1'b0);
        step();
        check("stray_err_set", err_o, 1'b1);
        step(); step();
        check("stray_err_sticky", err_o, 1'b1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check("err_cleared_by_rst", err_o, 1'b0);
        step();

        check("sb_gnt_empty", 64'(gnt_exp_q.size()), 64'd0);
        check("sb_rsp_empty", 64'(rsp_exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-to-one arbiter that shares the single req/gnt/rvalid memory port (`memory_sim`) between the core's instruction-fetch and load/store units. It selects one requester per cycle, forwards its request combinationally, and records the owner of every granted transaction. Each rvalid response then returns only to the unit that issued it. It sits between the datapath/control unit and the memory model, with zero added latency on the request path.

## Interface
- `MAX_OUTSTANDING`, default 2: granted transactions awaiting rvalid; power of two, ≥1.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `instr_req_i` / `instr_adr_i` in 1 / ADDR_W: fetch request and address (read-only).
- `instr_gnt_o` / `instr_rvalid_o` out 1 / 1: fetch grant and response valid.
- `instr_rdata_o` out DATA_W: fetch read data.
- `data_req_i` / `data_adr_i` in 1 / ADDR_W: load/store request and address.
- `data_we_i` / `data_wdata_i` in 1 / DATA_W: write enable and write data.
- `data_gnt_o` / `data_rvalid_o` out 1 / 1: load/store grant and response valid.
- `data_rdata_o` out DATA_W: load/store read data.
- `mem_req_o` / `mem_adr_o` / `mem_we_o` / `mem_wdata_o` out 1 / ADDR_W / 1 / DATA_W: request to memory (`mem_we_o` is active-high write).
- `mem_gnt_i` / `mem_rvalid_i` / `mem_rdata_i` in 1 / 1 / DATA_W: memory grant, response valid, read data.
- `err_o` out 1: sticky flag; set by an rvalid arriving with no outstanding transaction.

## Operation
- Owner FIFO: depth MAX_OUTSTANDING, 1-bit entries (INSTR/DATA).
  - Push the owner on `mem_req_o & mem_gnt_i`.
  - Pop on `mem_rvalid_i`.
  - Writes are tracked as well, because the memory returns rvalid for writes.
- Block: `mem_req_o` is forced low while the FIFO is full and no pop occurs this cycle.
  - When full and popping, a push in the same cycle is allowed.
  - Occupancy stays at MAX_OUTSTANDING.
- Arbitration: round-robin.
  - `last_grant` register is updated on every memory grant.
  - When both units request, the unit that was not `last_grant` wins.
  - When only one unit requests, it wins.
- Lock: if `mem_req_o` is high and `mem_gnt_i` is low, the current selection is latched.
  - It is held every following cycle until granted, regardless of priority.
  - Requesters must hold req/adr/we/wdata stable until their gnt.
- Request mux, combinational from the selected unit:
  - `mem_adr_o`, `mem_we_o` (forced 0 for INSTR), `mem_wdata_o`.
  - `mem_req_o = (instr_req_i | data_req_i) & ~block`.
- Grant return: selected unit's gnt = `mem_gnt_i & mem_req_o`; the other unit's gnt = 0.
- Response routing:
  - `instr_rvalid_o = mem_rvalid_i & head==INSTR`.
  - `data_rvalid_o = mem_rvalid_i & head==DATA`.
  - `mem_rdata_i` is broadcast to both rdata outputs.
- Stray rvalid (FIFO empty): set `err_o`, route to nobody, pop nothing.
- Reset state:
  - FIFO empty, lock clear, `err_o`=0.
  - `last_grant`=INSTR, so DATA wins the first contention.
- Reset mid-operation: in-flight entries are discarded. Responses arriving after reset deasserts are stray and set `err_o`.

## Timing
- Request path: purely combinational, 0 cycles; gnt is returned in the same cycle as `mem_gnt_i`.
- Response path: combinational from `mem_rvalid_i` and the FIFO head; response latency equals the memory latency.
- Registered state updates on the rising edge after the event: FIFO pointers/count, `last_grant`, lock, `err_o`.
- Behaviour during `rst_i`=1:
  - All outputs other than `err_o` and `mem_*_o` data fields are 0.
  - `mem_req_o`=0, and grants/rvalids are suppressed.
- Throughput with a 1-cycle memory and MAX_OUTSTANDING ≥2: one grant per cycle sustained.

## Structure
- Package `mem_arb_pkg`: `owner_e` enum (`OWNER_INSTR`=0, `OWNER_DATA`=1).
- Sub-module `owner_fifo`: parameterised depth, 1-bit data, with push/pop/full/empty/head. The same-cycle push-when-full-with-pop case is handled inside it.
- Top level: the arbiter FSM (lock and `last_grant` registers) and the muxes.

## Test plan
- Instr-only stream: fetches to 0x1A00_0000, 0x1A00_0004, 0x1A00_0008, memory always granting, 1-cycle latency. Each `instr_gnt_o` follows `mem_gnt_i` in the same cycle. Three `instr_rvalid_o` pulses carry the correct words. `data_*` outputs stay 0.
- Contention after reset: both units request continuously. Grant order is DATA, INSTR, DATA, INSTR. Each rvalid is routed to the matching unit in grant order.
- Stall lock: INSTR is selected and `mem_gnt_i`=0 for 3 cycles while DATA also requests. The selection stays INSTR and `mem_adr_o` is unchanged. When `mem_gnt_i` rises, INSTR is granted, then DATA is granted the next cycle.
- Full FIFO: MAX_OUTSTANDING=2, rvalid withheld. After 2 grants, `mem_req_o`=0. When rvalid arrives and a request is pending, a push and pop occur in the same cycle and the grant is issued.
- Store then load: store 0xDEADBEEF to 0x1A00_0010, then load the same address. `mem_we_o`=1 then 0. `data_rvalid_o` pulses twice. The second `data_rdata_o`=0xDEADBEEF.
- Stray rvalid and reset mid-flight: assert `rst_i` with 1 transaction outstanding, then deliver rvalid. `err_o`=1 and stays set. No `*_rvalid_o` is asserted. A later `rst_i` clears `err_o`.
